// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
// npc_pkg : shared fetch-unit states, entry layout and instruction constants
// Revision : 1.0
// ============================================================================
package npc_pkg;

  localparam logic [63:0] c_reset_pc = 64'h0000_0000_8000_0000;
  localparam logic [31:0] c_nop      = 32'h0000_0013;
  localparam logic [31:0] c_ebreak   = 32'h0010_0073;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifu_fifo.sv
`default_nettype none
// ============================================================================
// ifu_fifo : synchronous instruction buffer with push/pop/flush and occupancy
// Revision : 1.0
// ============================================================================
module ifu_fifo #(
  parameter int               WIDTH      = 96,
  parameter int               DEPTH      = 2,
  parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_empty;
  logic             w_full;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [AW:0]      w_count_next;

  assign w_full       = (r_count == c_depth);
  assign w_pop_ok     = pop && !r_empty;
  // A full buffer still accepts a push when the head leaves on the same edge
  assign w_push_ok    = push && (!w_full || w_pop_ok);
  assign w_count_next = r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= RESET_WORD;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      assert (!(push && w_full && !pop))
        else $error("ifu_fifo: push into a full buffer");
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign empty = r_empty;
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// ifu_fetch : single-outstanding instruction fetch with redirect, halt, buffer
// Revision : 1.0
// ============================================================================
module ifu_fetch
  import npc_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = c_reset_pc,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] c_depth = CW'(FIFO_DEPTH);

  fetch_state_t  r_state;
  fetch_state_t  w_state_next;
  logic [63:0]   r_pc;
  logic          r_kill;
  logic          w_accept;
  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_room;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_after;
  fetch_entry_t  w_wdata;
  fetch_entry_t  w_head;

  assign imem_req_valid = (r_state == REQ) && !halt;
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_resp         = (r_state == WAIT) && imem_resp_valid;
  assign w_push         = w_resp && !r_kill && !redirect_valid;
  assign w_pop          = out_valid && out_ready;
  assign w_count_after  = w_count + CW'(w_push) - CW'(w_pop);
  // The buffer is the only in-flight sink, so post-edge occupancy bounds issue
  assign w_room         = !halt && (w_count_after < c_depth);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (redirect_valid || w_room) w_state_next = REQ;
      REQ:     if (w_accept) w_state_next = WAIT;
      WAIT:    if (w_resp) w_state_next = (redirect_valid || w_room) ? REQ : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (redirect_valid) begin
        r_pc   <= redirect_pc & ~64'd3;
        // Anything still owed by memory after this edge belongs to the old path
        r_kill <= ((r_state == WAIT) && !imem_resp_valid) || w_accept;
      end else begin
        if (w_push) r_pc <= r_pc + 64'd4;
        if (w_resp) r_kill <= 1'b0;
      end
    end
  end

  assign w_wdata = {imem_resp_data, r_pc};

  ifu_fifo #(
    .WIDTH      ($bits(fetch_entry_t)),
    .DEPTH      (FIFO_DEPTH),
    .RESET_WORD ({c_nop, 64'd0})
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata (w_wdata),
    .rdata (w_head),
    .empty (w_empty),
    .count (w_count)
  );

  assign out_valid = !w_empty;
  assign out_inst  = w_head.inst;
  assign out_pc    = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// tb_ifu_fetch : vector table, directed corner sequences, randomized stream
// Revision : 1.0
// ============================================================================
module tb_ifu_fetch;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;

  int checks   = 0;
  int failures = 0;

  ifu_fetch dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory contents: an ebreak at 0x80000004, elsewhere an address hash
  function automatic logic [31:0] memf(input logic [63:0] a);
    if (a == 64'h8000_0004) return EBREAK;
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0000;
  endfunction

  // ---------------- automatic memory model ----------------
  logic        mem_auto = 1'b0;
  int          ready_pct = 100;
  int          lat_max = 0;
  logic        spur_en = 1'b0;
  logic        pend = 1'b0;
  logic        drove = 1'b0;
  logic [63:0] pend_addr = '0;
  int          pend_wait = 0;
  logic        m_acc = 1'b0;
  logic [63:0] m_addr = '0;

  always @(negedge clock) begin
    m_acc  = imem_req_valid && imem_req_ready && !reset;
    m_addr = imem_req_addr;
  end

  always @(posedge clock) begin
    #1;
    if (mem_auto) begin
      if (drove) pend = 1'b0;
      drove = 1'b0;
      if (m_acc) begin
        chk("one_outstanding", {63'd0, pend}, 64'd0);
        pend      = 1'b1;
        pend_addr = m_addr;
        pend_wait = $urandom_range(lat_max, 0);
      end
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      if (pend) begin
        if (pend_wait == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = memf(pend_addr);
          drove           = 1'b1;
        end else begin
          pend_wait--;
        end
      end else if (spur_en && ($urandom_range(9, 0) == 0)) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
      end
      imem_req_ready = ($urandom_range(99, 0) < ready_pct);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    mem_auto        = 1'b0;
    pend            = 1'b0;
    drove           = 1'b0;
    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'h0;
    halt            = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rd;
    logic        ordy;
    logic        ev;
    logic [63:0] ea;
    logic        eov;
    logic [63:0] epc;
    logic [31:0] einst;
    logic        chkd;
  } vec_t;

  vec_t        tbl [10];
  logic        found;
  int          pops;
  logic [63:0] exp_pc;
  logic        post_redir;
  logic        prev_stall;
  logic [63:0] prev_addr;

  initial begin
    #400000;
    $display("FAIL timeout: simulation still running, required finished");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------- table: reset values, first-fetch latency, backpressure ----------
    tbl[0] = '{1'b0, 32'h0,          1'b0, 1'b0, 64'h8000_0000, 1'b0, 64'h0,          NOP,           1'b1};
    tbl[1] = '{1'b0, 32'h0,          1'b0, 1'b1, 64'h8000_0000, 1'b0, 64'h0,          NOP,           1'b1};
    tbl[2] = '{1'b1, NOP,            1'b0, 1'b0, 64'h8000_0000, 1'b0, 64'h0,          NOP,           1'b1};
    tbl[3] = '{1'b0, 32'h0,          1'b0, 1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000, NOP,           1'b1};
    tbl[4] = '{1'b1, 32'h0050_0093,  1'b0, 1'b0, 64'h8000_0004, 1'b1, 64'h8000_0000, NOP,           1'b1};
    tbl[5] = '{1'b0, 32'h0,          1'b0, 1'b0, 64'h8000_0008, 1'b1, 64'h8000_0000, NOP,           1'b1};
    tbl[6] = '{1'b0, 32'h0,          1'b1, 1'b0, 64'h8000_0008, 1'b1, 64'h8000_0000, NOP,           1'b1};
    tbl[7] = '{1'b0, 32'h0,          1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004, 32'h0050_0093, 1'b1};
    tbl[8] = '{1'b1, NOP,            1'b1, 1'b0, 64'h8000_0008, 1'b0, 64'h0,          32'h0,         1'b0};
    tbl[9] = '{1'b0, 32'h0,          1'b0, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_0008, NOP,           1'b1};

    do_reset();
    imem_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      imem_resp_valid = tbl[i].rv;
      imem_resp_data  = tbl[i].rd;
      out_ready       = tbl[i].ordy;
      @(negedge clock);
      chk($sformatf("tbl%0d_req_valid", i), {63'd0, imem_req_valid}, {63'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].ea);
      chk($sformatf("tbl%0d_out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].eov});
      if (tbl[i].chkd) begin
        chk($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_out_inst", i), {32'd0, out_inst}, {32'd0, tbl[i].einst});
      end
      step();
    end

    // ---------- redirect while waiting: stale response dropped ----------
    do_reset();
    imem_req_ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1002;
    step();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("a_wait_no_req", {63'd0, imem_req_valid}, 64'd0);
    step();
    imem_resp_valid = 1'b0;
    @(negedge clock);
    chk("a_stale_dropped", {63'd0, out_valid}, 64'd0);
    chk("a_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("a_req_addr", imem_req_addr, 64'h8000_1000);
    step();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1111_0013;
    step();
    imem_resp_valid = 1'b0;
    @(negedge clock);
    chk("a_out_valid", {63'd0, out_valid}, 64'd1);
    chk("a_out_pc", out_pc, 64'h8000_1000);
    chk("a_out_inst", {32'd0, out_inst}, 64'h1111_0013);
    step();

    // ---------- redirect + response + pop on the same edge ----------
    do_reset();
    imem_req_ready = 1'b1;
    step();
    step();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0AAA_0013;
    step();
    imem_resp_valid = 1'b0;
    step();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0BBB_0013;
    out_ready       = 1'b1;
    redirect_valid  = 1'b1;
    redirect_pc     = 64'h0000_0000_9000_0004;
    @(negedge clock);
    chk("b_head_present", {63'd0, out_valid}, 64'd1);
    step();
    imem_resp_valid = 1'b0;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    imem_req_ready  = 1'b0;
    @(negedge clock);
    chk("b_out_valid", {63'd0, out_valid}, 64'd0);
    chk("b_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("b_req_addr", imem_req_addr, 64'h9000_0004);
    step();
    @(negedge clock);
    chk("b_still_empty", {63'd0, out_valid}, 64'd0);
    chk("b_addr_hold", imem_req_addr, 64'h9000_0004);
    step();

    // ---------- reset during WAIT, response on the following cycle ----------
    do_reset();
    imem_req_ready = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    reset           = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_0013;
    @(negedge clock);
    chk("d_idle_no_req", {63'd0, imem_req_valid}, 64'd0);
    chk("d_addr_reset", imem_req_addr, 64'h8000_0000);
    step();
    imem_resp_valid = 1'b0;
    @(negedge clock);
    chk("d_resp_ignored", {63'd0, out_valid}, 64'd0);
    chk("d_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("d_req_addr", imem_req_addr, 64'h8000_0000);
    step();
    imem_resp_valid = 1'b1;
    imem_resp_data  = NOP;
    step();
    imem_resp_valid = 1'b0;
    @(negedge clock);
    chk("d_out_valid", {63'd0, out_valid}, 64'd1);
    chk("d_out_pc", out_pc, 64'h8000_0000);
    chk("d_out_inst", {32'd0, out_inst}, {32'd0, NOP});
    step();

    // ---------- halt raised the cycle ebreak reaches decode ----------
    do_reset();
    ready_pct = 100;
    lat_max   = 0;
    spur_en   = 1'b0;
    mem_auto  = 1'b1;
    out_ready = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (out_valid && out_inst == EBREAK) found = 1'b1;
    end
    halt      = 1'b1;
    out_ready = 1'b0;
    chk("c_ebreak_seen", {63'd0, found}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("c_halt_req_valid", {63'd0, imem_req_valid}, 64'd0);
      chk("c_halt_head_valid", {63'd0, out_valid}, 64'd1);
      chk("c_halt_head_pc", out_pc, 64'h8000_0004);
      chk("c_halt_head_inst", {32'd0, out_inst}, {32'd0, EBREAK});
      step();
    end
    halt      = 1'b0;
    out_ready = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_valid && out_pc == 64'h8000_0008) found = 1'b1;
      step();
    end
    chk("c_resume_pc", {63'd0, found}, 64'd1);

    // ---------- randomized stream against the in-order PC model ----------
    do_reset();
    ready_pct  = 70;
    lat_max    = 3;
    spur_en    = 1'b1;
    mem_auto   = 1'b1;
    exp_pc     = 64'h8000_0000;
    post_redir = 1'b0;
    prev_stall = 1'b0;
    prev_addr  = '0;
    pops       = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      out_ready = ($urandom_range(99, 0) < 70);
      if (halt) halt = ($urandom_range(99, 0) < 80);
      else      halt = ($urandom_range(99, 0) < 3);
      redirect_valid = ($urandom_range(99, 0) < 4);
      if ($urandom_range(3, 0) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
      else                           redirect_pc = {$urandom, $urandom};
      @(negedge clock);
      if (post_redir) chk("r_redirect_bubble", {63'd0, out_valid}, 64'd0);
      chk("r_addr_align", {62'd0, imem_req_addr[1:0]}, 64'd0);
      if (halt) chk("r_halt_no_req", {63'd0, imem_req_valid}, 64'd0);
      if (prev_stall) chk("r_addr_hold", imem_req_addr, prev_addr);
      prev_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
      prev_addr  = imem_req_addr;
      post_redir = redirect_valid;
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~64'd3;
      end else if (out_valid && out_ready) begin
        chk("r_out_pc", out_pc, exp_pc);
        chk("r_out_inst", {32'd0, out_inst}, {32'd0, memf(exp_pc)});
        exp_pc = exp_pc + 64'd4;
        pops++;
      end
      step();
    end
    chk("r_liveness", {63'd0, (pops > 200)}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of instruction buffer entries; legal values are powers of two, 2 to 8.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-006 SHALL have port imem_req_ready, input, 1, memory accepts the request.
REQ-007 SHALL have port imem_req_addr, output, 64, fetch address with bits [1:0] always 0.
REQ-008 SHALL have port imem_resp_valid, input, 1, response data valid.
REQ-009 SHALL have port imem_resp_data, input, 32, the fetched instruction word.
REQ-010 SHALL have port out_valid, output, 1, an instruction is offered to decode.
REQ-011 SHALL have port out_ready, input, 1, decode accepts the instruction.
REQ-012 SHALL have port out_inst, output, 32, the instruction; it feeds the downstream ebreak/trap monitor.
REQ-013 SHALL have port out_pc, output, 64, the PC of out_inst.
REQ-014 SHALL have port redirect_valid, input, 1, branch, jump or trap redirect.
REQ-015 SHALL have port redirect_pc, input, 64, redirect target; bits [1:0] are ignored.
REQ-016 SHALL have port halt, input, 1, the level-sensitive stop-fetch signal from the ebreak monitor.

Function
REQ-017 SHALL implement FSM states IDLE, REQ and WAIT.
- IDLE -> REQ when halt=0 and free FIFO slots are at least 1.
- REQ -> WAIT on imem_req_valid && imem_req_ready.
- WAIT -> IDLE or REQ on imem_resp_valid.
REQ-018 SHALL assert imem_req_valid only in REQ, and SHALL hold imem_req_addr stable while valid && !ready.
REQ-019 SHALL allow at most one outstanding request, and SHALL issue a request only if the FIFO count plus in-flight count is less than FIFO_DEPTH.
REQ-020 SHALL, on an accepted response, write {data, fetch PC} into the FIFO and advance the PC by 4 (64-bit modular wrap, no overflow flag).
REQ-021 SHALL present the FIFO head on out_inst/out_pc with out_valid = !empty; the head pops on out_valid && out_ready.
REQ-022 SHALL give a minimum latency of 2 cycles from request acceptance to out_valid when the response arrives the cycle after acceptance; out_valid is registered.
REQ-023 SHALL, on redirect_valid, in the same edge: flush the FIFO; set PC = {redirect_pc[63:2], 2'b00}; go to REQ if no request is in flight.
REQ-024 SHALL, if a redirect occurs with a request in flight, set a kill flag; the matching response is discarded, not enqueued, and the FSM then proceeds to REQ at the new PC.
REQ-025 SHALL give redirect priority over a same-cycle response and over a same-cycle pop; out_valid is 0 on the cycle after a redirect.
REQ-026 SHALL stop issuing new requests while halt=1. An in-flight response SHALL still be enqueued; FIFO contents stay visible and poppable. Fetching resumes from the current PC when halt drops.
REQ-027 SHALL, when the FIFO is full, refuse enqueue; REQ-019 guarantees this never occurs, and a violation SHALL be flagged by an assertion.
REQ-028 SHALL, with a simultaneous push and pop on a full FIFO, perform both; the count is unchanged.
REQ-029 SHALL ignore imem_resp_valid outside WAIT.

Reset
REQ-030 SHALL, on reset, set PC = RESET_PC, FSM = IDLE, FIFO empty, kill = 0, in-flight = 0.
REQ-031 SHALL drive these output reset values: imem_req_valid = 0, imem_req_addr = RESET_PC, out_valid = 0, out_inst = 32'h0000_0013 (nop), out_pc = 0.
REQ-032 SHALL, on reset asserted mid-transaction, abandon the outstanding request; the first response after reset is ignored unless a new request has been accepted.

Structure
REQ-033 SHALL place FSM state enum, RESET_PC default, NOP and EBREAK (32'h0010_0073) constants in the shared package npc_pkg.
REQ-034 SHALL implement the instruction buffer as sub-module ifu_fifo (sync FIFO, parameterised width/depth, push/pop/flush/count).

Verification
REQ-035 Reset then zero-wait memory returning 0x00000013 -> first out_pc 0x80000000, subsequent 0x80000004, 0x80000008; out_valid first high on cycle 3 after reset release.
REQ-036 out_ready=0 with memory always ready -> exactly 2 words buffered, imem_req_valid stays 0 afterwards, no data lost when out_ready rises.
REQ-037 Redirect to 0x80001002 while in WAIT -> stale response dropped; next out_pc 0x80001000.
REQ-038 Redirect, response and pop all in the same cycle -> FIFO empty next cycle; out_valid=0; next request address = redirect target.
REQ-039 Instruction stream containing 0x00100073 with halt asserted the cycle it appears on out_inst -> no further imem_req_valid; remaining buffered words unchanged.
REQ-040 Reset asserted during WAIT with the response arriving on the following cycle -> response ignored; fetch restarts at 0x80000000.
